// File: rtl/rx_ack_decision_if.sv
// Parser-side header fields and TX-side ACK request signals for rx_ack_decision.
// master = parser/TX environment, slave = the ACK decision block.
interface rx_ack_decision_if;
  logic [47:0] self_mac;
  logic [31:0] FC_DI;
  logic        FC_DI_valid;
  logic [47:0] rx_addr;
  logic        rx_addr_valid;
  logic [47:0] tx_addr;
  logic        tx_addr_valid;
  logic [15:0] SC;
  logic        SC_valid;
  logic [1:0]  qos_ack_policy;
  logic        qos_ack_policy_valid;
  logic        fcs_valid;
  logic        fcs_ok;
  logic [15:0] sifs_cycles;
  logic        ack_grant;
  logic        ack_req;
  logic [47:0] ack_ra;
  logic [15:0] ack_duration;
  logic        ack_drop;
  logic        rx_dup;
  logic        rx_for_me;

  modport master (
    output self_mac, FC_DI, FC_DI_valid, rx_addr, rx_addr_valid, tx_addr, tx_addr_valid,
           SC, SC_valid, qos_ack_policy, qos_ack_policy_valid, fcs_valid, fcs_ok,
           sifs_cycles, ack_grant,
    input  ack_req, ack_ra, ack_duration, ack_drop, rx_dup, rx_for_me
  );

  modport slave (
    input  self_mac, FC_DI, FC_DI_valid, rx_addr, rx_addr_valid, tx_addr, tx_addr_valid,
           SC, SC_valid, qos_ack_policy, qos_ack_policy_valid, fcs_valid, fcs_ok,
           sifs_cycles, ack_grant,
    output ack_req, ack_ra, ack_duration, ack_drop, rx_dup, rx_for_me
  );
endinterface

// File: rtl/rx_ack_decision.sv
// Collects a received MAC header, decides whether an ACK is owed, waits SIFS
// and then holds an ACK request toward the TX side until it is granted.
module rx_ack_decision #(
  parameter int unsigned ACK_DUR_SUB = 44
) (
  input  logic             clk,
  input  logic             rstn,
  rx_ack_decision_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HDR, DECIDE, SIFS, REQ} state_t;

  state_t      r_state;
  logic [1:0]  r_fc_type;
  logic        r_fc_retry;
  logic [15:0] r_di;
  logic [47:0] r_ra;
  logic [47:0] r_ta;
  logic [11:0] r_seq;
  logic [1:0]  r_qos;
  logic        r_rx_seen;
  logic        r_tx_seen;
  logic        r_sc_seen;
  logic        r_qos_seen;
  logic        r_fcs_ok;
  logic        r_last_valid;
  logic [47:0] r_last_ta;
  logic [11:0] r_last_seq;
  logic [15:0] r_cnt;
  logic        r_fc_valid_d;
  logic        r_ack_req;
  logic [47:0] r_ack_ra;
  logic [15:0] r_ack_duration;
  logic        r_ack_drop;
  logic        r_rx_dup;
  logic        r_rx_for_me;

  logic        w_fc_rise;
  logic        w_start_hdr;
  logic        w_for_me;
  logic        w_type_ok;
  logic        w_need_ack;
  logic        w_dup;
  logic [16:0] w_di_diff;
  logic [15:0] w_ack_dur;
  logic [15:0] w_sifs_last;

  assign w_fc_rise   = bus.FC_DI_valid & ~r_fc_valid_d;
  assign w_for_me    = r_fcs_ok & (r_ra == bus.self_mac) & ~r_ra[0];
  assign w_type_ok   = (r_fc_type == 2'b00) | (r_fc_type == 2'b10);
  assign w_need_ack  = w_for_me & r_rx_seen & r_tx_seen & w_type_ok &
                       ~(r_qos_seen & (r_qos != 2'b00));
  assign w_dup       = w_for_me & r_fc_retry & r_sc_seen & r_last_valid &
                       (r_ta == r_last_ta) & (r_seq == r_last_seq);
  // Borrow out of bit 16 means DI < ACK_DUR_SUB; DI[15] marks an AID, not a duration.
  assign w_di_diff   = {1'b0, r_di} - 17'(ACK_DUR_SUB);
  assign w_ack_dur   = (r_di[15] | w_di_diff[16]) ? 16'd0 : w_di_diff[15:0];
  assign w_sifs_last = (bus.sifs_cycles == 16'd0) ? 16'd0 : bus.sifs_cycles - 16'd1;

  always_comb begin
    w_start_hdr = 1'b0;
    case (r_state)
      IDLE:      w_start_hdr = bus.FC_DI_valid;
      SIFS, REQ: w_start_hdr = w_fc_rise;
      default:   w_start_hdr = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state        <= IDLE;
      r_fc_type      <= 2'b00;
      r_fc_retry     <= 1'b0;
      r_di           <= 16'd0;
      r_ra           <= 48'd0;
      r_ta           <= 48'd0;
      r_seq          <= 12'd0;
      r_qos          <= 2'b00;
      r_rx_seen      <= 1'b0;
      r_tx_seen      <= 1'b0;
      r_sc_seen      <= 1'b0;
      r_qos_seen     <= 1'b0;
      r_fcs_ok       <= 1'b0;
      r_last_valid   <= 1'b0;
      r_last_ta      <= 48'd0;
      r_last_seq     <= 12'd0;
      r_cnt          <= 16'd0;
      r_fc_valid_d   <= 1'b0;
      r_ack_req      <= 1'b0;
      r_ack_ra       <= 48'd0;
      r_ack_duration <= 16'd0;
      r_ack_drop     <= 1'b0;
      r_rx_dup       <= 1'b0;
      r_rx_for_me    <= 1'b0;
    end else begin
      r_fc_valid_d <= bus.FC_DI_valid;
      r_ack_drop   <= 1'b0;
      r_rx_dup     <= 1'b0;
      r_rx_for_me  <= 1'b0;
      if (w_start_hdr) begin
        r_fc_type  <= bus.FC_DI[3:2];
        r_fc_retry <= bus.FC_DI[11];
        r_di       <= bus.FC_DI[31:16];
        r_rx_seen  <= 1'b0;
        r_tx_seen  <= 1'b0;
        r_sc_seen  <= 1'b0;
        r_qos_seen <= 1'b0;
        r_ack_req  <= 1'b0;
        // A grant arriving with the new header means the ACK went out; no drop.
        r_ack_drop <= (r_state == SIFS) | ((r_state == REQ) & ~bus.ack_grant);
        r_state    <= HDR;
      end else begin
        case (r_state)
          HDR: begin
            if (bus.rx_addr_valid) begin
              r_ra      <= bus.rx_addr;
              r_rx_seen <= 1'b1;
            end
            if (bus.tx_addr_valid) begin
              r_ta      <= bus.tx_addr;
              r_tx_seen <= 1'b1;
            end
            if (bus.SC_valid) begin
              r_seq     <= bus.SC[15:4];
              r_sc_seen <= 1'b1;
            end
            if (bus.qos_ack_policy_valid) begin
              r_qos      <= bus.qos_ack_policy;
              r_qos_seen <= 1'b1;
            end
            if (bus.fcs_valid) begin
              r_fcs_ok <= bus.fcs_ok;
              r_state  <= DECIDE;
            end else if (bus.FC_DI_valid) begin
              r_fc_type  <= bus.FC_DI[3:2];
              r_fc_retry <= bus.FC_DI[11];
              r_di       <= bus.FC_DI[31:16];
            end
          end
          DECIDE: begin
            r_ack_ra       <= r_ta;
            r_ack_duration <= w_ack_dur;
            r_rx_for_me    <= w_for_me;
            r_rx_dup       <= w_dup;
            if (w_for_me & r_sc_seen) begin
              r_last_valid <= 1'b1;
              r_last_ta    <= r_ta;
              r_last_seq   <= r_seq;
            end
            r_cnt   <= 16'd0;
            r_state <= w_need_ack ? SIFS : IDLE;
          end
          SIFS: begin
            if (r_cnt >= w_sifs_last) begin
              r_ack_req <= 1'b1;
              r_state   <= REQ;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          REQ: begin
            if (bus.ack_grant) begin
              r_ack_req <= 1'b0;
              r_state   <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ack_req      = r_ack_req;
  assign bus.ack_ra       = r_ack_ra;
  assign bus.ack_duration = r_ack_duration;
  assign bus.ack_drop     = r_ack_drop;
  assign bus.rx_dup       = r_rx_dup;
  assign bus.rx_for_me    = r_rx_for_me;

endmodule

// File: tb/tb_rx_ack_decision.sv
// Randomized frame-level bench for rx_ack_decision against a per-frame
// reference model of the ACK/duplicate rules.
module tb_rx_ack_decision;
  localparam int          SUB  = 44;
  localparam logic [47:0] SELF = 48'h0211_2233_4450;
  localparam logic [47:0] TA_A = 48'hA0A1_A2A3_A4A6;
  localparam logic [47:0] TA_B = 48'hB0B1_B2B3_B4B6;

  typedef struct {
    logic [15:0] fc;
    logic [15:0] di;
    logic [47:0] ra;
    logic [47:0] ta;
    logic [15:0] sc;
    bit          has_sc;
    bit          has_qos;
    logic [1:0]  qos;
    bit          ok;
    logic [15:0] sifs;
  } frame_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  bit          m_last_valid = 1'b0;
  logic [47:0] m_last_ta = '0;
  logic [11:0] m_last_seq = '0;

  always #5 clk = ~clk;

  rx_ack_decision_if bus ();

  rx_ack_decision #(.ACK_DUR_SUB(SUB)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.FC_DI_valid          = 1'b0;
    bus.rx_addr_valid        = 1'b0;
    bus.tx_addr_valid        = 1'b0;
    bus.SC_valid             = 1'b0;
    bus.qos_ack_policy_valid = 1'b0;
    bus.fcs_valid            = 1'b0;
    bus.fcs_ok               = 1'b0;
    bus.ack_grant            = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack_req"}, bus.ack_req, 1'b0);
    chk({tag, "_ack_ra"}, bus.ack_ra, 48'd0);
    chk({tag, "_ack_dur"}, bus.ack_duration, 16'd0);
    chk({tag, "_ack_drop"}, bus.ack_drop, 1'b0);
    chk({tag, "_rx_dup"}, bus.rx_dup, 1'b0);
    chk({tag, "_rx_for_me"}, bus.rx_for_me, 1'b0);
  endtask

  function automatic frame_t mk(input logic [15:0] fc, input logic [15:0] di,
                                input logic [47:0] ra, input logic [47:0] ta,
                                input logic [15:0] sc, input bit ok, input logic [15:0] sifs);
    frame_t f;
    f.fc = fc; f.di = di; f.ra = ra; f.ta = ta; f.sc = sc;
    f.has_sc = 1'b1; f.has_qos = 1'b0; f.qos = 2'b00; f.ok = ok; f.sifs = sifs;
    return f;
  endfunction

  task automatic hdr_start(input frame_t f);
    bus.FC_DI       = {f.di, f.fc};
    bus.sifs_cycles = f.sifs;
    bus.FC_DI_valid = 1'b1;
    tick();
    bus.FC_DI_valid = 1'b0;
  endtask

  task automatic hdr_fields(input frame_t f);
    bus.rx_addr = f.ra; bus.rx_addr_valid = 1'b1; tick(); bus.rx_addr_valid = 1'b0;
    bus.tx_addr = f.ta; bus.tx_addr_valid = 1'b1; tick(); bus.tx_addr_valid = 1'b0;
    if (f.has_sc) begin
      bus.SC = f.sc; bus.SC_valid = 1'b1; tick(); bus.SC_valid = 1'b0;
    end
    if (f.has_qos) begin
      bus.qos_ack_policy = f.qos; bus.qos_ack_policy_valid = 1'b1; tick();
      bus.qos_ack_policy_valid = 1'b0;
    end
    bus.fcs_ok = f.ok; bus.fcs_valid = 1'b1; tick();
    bus.fcs_valid = 1'b0; bus.fcs_ok = 1'b0;
  endtask

  // mode 0: full handshake; 1: stop 3 cycles into the SIFS wait; 2: stop with ack_req high
  task automatic finish(input string tag, input frame_t f, input int mode);
    bit          fme, nack, dup;
    logic [15:0] dur;
    int          se, hold;
    fme  = f.ok && (f.ra == SELF) && !f.ra[0];
    nack = fme && (f.fc[3:2] == 2'b00 || f.fc[3:2] == 2'b10) && !(f.has_qos && f.qos != 2'b00);
    dup  = fme && f.fc[11] && f.has_sc && m_last_valid && (f.ta == m_last_ta) &&
           (f.sc[15:4] == m_last_seq);
    if (f.di[15]) dur = 16'd0;
    else if (int'(f.di) > SUB) dur = 16'(int'(f.di) - SUB);
    else dur = 16'd0;
    if (fme && f.has_sc) begin
      m_last_valid = 1'b1; m_last_ta = f.ta; m_last_seq = f.sc[15:4];
    end
    se = (f.sifs == 16'd0) ? 1 : int'(f.sifs);
    $display("frame %s: fc=%h di=%h ra=%h ta=%h sc=%h ok=%0d sifs=%0d -> for_me=%0d ack=%0d dup=%0d dur=%h",
             tag, f.fc, f.di, f.ra, f.ta, f.sc, f.ok, f.sifs, fme, nack, dup, dur);
    tick();
    chk({tag, "_rx_for_me"}, bus.rx_for_me, fme);
    chk({tag, "_rx_dup"}, bus.rx_dup, dup);
    chk({tag, "_no_drop"}, bus.ack_drop, 1'b0);
    if (!nack) begin
      for (int i = 1; i <= se + 2; i++) begin
        tick();
        if (i == 1) chk({tag, "_for_me_pulse"}, bus.rx_for_me, 1'b0);
        chk({tag, "_no_ack_req"}, bus.ack_req, 1'b0);
      end
      return;
    end
    for (int i = 1; i <= se; i++) begin
      if (mode == 1 && i > 3) return;
      tick();
      if (i == 1) chk({tag, "_for_me_pulse"}, bus.rx_for_me, 1'b0);
      chk({tag, "_ack_req_timing"}, bus.ack_req, (i == se));
    end
    chk({tag, "_ack_ra"}, bus.ack_ra, f.ta);
    chk({tag, "_ack_dur"}, bus.ack_duration, dur);
    if (mode == 2) return;
    hold = $urandom_range(0, 3);
    repeat (hold) begin
      tick();
      chk({tag, "_ack_req_hold"}, bus.ack_req, 1'b1);
      chk({tag, "_ack_ra_hold"}, bus.ack_ra, f.ta);
    end
    bus.ack_grant = 1'b1;
    tick();
    bus.ack_grant = 1'b0;
    chk({tag, "_ack_req_after_grant"}, bus.ack_req, 1'b0);
    chk({tag, "_grant_no_drop"}, bus.ack_drop, 1'b0);
    tick();
    chk({tag, "_idle_after_grant"}, bus.ack_req, 1'b0);
  endtask

  task automatic send(input string tag, input frame_t f);
    hdr_start(f);
    hdr_fields(f);
    finish(tag, f, 0);
  endtask

  initial begin
    frame_t f, g;
    bus.self_mac = SELF;
    bus.FC_DI = '0; bus.rx_addr = '0; bus.tx_addr = '0; bus.SC = '0;
    bus.qos_ack_policy = '0; bus.sifs_cycles = 16'd10;
    idle_inputs();
    repeat (3) tick();
    chk_all_zero("reset");
    rstn = 1'b1;
    tick();

    // Basic data frame, then the no-ACK variants
    f = mk(16'h0008, 16'h013C, SELF, TA_A, 16'h0120, 1'b1, 16'd10);
    send("basic", f);
    f.ok = 1'b0; send("bad_fcs", f);
    f.ok = 1'b1; f.ra = 48'hFFFF_FFFF_FFFF; send("bcast", f);
    f.ra = SELF; f.has_qos = 1'b1; f.qos = 2'b01; send("qos_noack", f);

    // Duplicate detection on a retransmission
    f = mk(16'h0008, 16'h0100, SELF, TA_B, 16'h0450, 1'b1, 16'd3);
    send("orig", f);
    f.fc[11] = 1'b1; f.sc[3:0] = 4'h0; send("retry", f);

    f = mk(16'h0008, 16'd20, SELF, TA_A, 16'h0990, 1'b1, 16'd0); send("short_di", f);
    f = mk(16'h0008, 16'h8005, SELF, TA_A, 16'h09A0, 1'b1, 16'd1); send("aid_di", f);
    f = mk(16'h00D4, 16'h0100, SELF, TA_A, 16'h09B0, 1'b1, 16'd2); send("ctrl", f);

    // New header during SIFS wait abandons the pending ACK
    f = mk(16'h0008, 16'h0200, SELF, TA_A, 16'h0A00, 1'b1, 16'd8);
    hdr_start(f); hdr_fields(f); finish("drop_a", f, 1);
    g = mk(16'h0088, 16'h0300, SELF, TA_B, 16'h0B00, 1'b1, 16'd2);
    hdr_start(g);
    chk("drop_pulse", bus.ack_drop, 1'b1);
    chk("drop_ack_req", bus.ack_req, 1'b0);
    tick();
    chk("drop_pulse_end", bus.ack_drop, 1'b0);
    hdr_fields(g); finish("drop_b", g, 0);

    // Grant and new header together: no drop, new header still collected
    f = mk(16'h0008, 16'h0050, SELF, TA_A, 16'h0C00, 1'b1, 16'd2);
    hdr_start(f); hdr_fields(f); finish("gnt_a", f, 2);
    g = mk(16'h0008, 16'h0400, SELF, TA_B, 16'h0D00, 1'b1, 16'd4);
    bus.FC_DI = {g.di, g.fc}; bus.sifs_cycles = g.sifs;
    bus.FC_DI_valid = 1'b1; bus.ack_grant = 1'b1;
    tick();
    bus.FC_DI_valid = 1'b0; bus.ack_grant = 1'b0;
    chk("gnt_fc_ack_req", bus.ack_req, 1'b0);
    chk("gnt_fc_no_drop", bus.ack_drop, 1'b0);
    hdr_fields(g); finish("gnt_b", g, 0);

    // Reset while requesting: everything clears and duplicate history is forgotten
    f = mk(16'h0008, 16'h0100, SELF, TA_A, 16'h0E00, 1'b1, 16'd2);
    hdr_start(f); hdr_fields(f); finish("rst_a", f, 2);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk_all_zero("rst_mid_req");
    m_last_valid = 1'b0;
    f.fc[11] = 1'b1;
    send("rst_b", f);

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      int r;
      f.fc = 16'($urandom);
      f.fc[3:2] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      f.fc[11] = $urandom_range(0, 1) == 1;
      f.di = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 120));
      r = $urandom_range(0, 19);
      f.ra = (r < 14) ? SELF : (r < 17) ? 48'hFFFF_FFFF_FFFF : {16'h1234, 32'($urandom)};
      f.ta = $urandom_range(0, 1) ? TA_A : TA_B;
      f.sc = {11'd0, 1'($urandom), 4'($urandom)};
      f.has_sc = $urandom_range(0, 4) != 0;
      f.has_qos = $urandom_range(0, 2) == 0;
      f.qos = 2'($urandom);
      f.ok = $urandom_range(0, 9) != 0;
      f.sifs = 16'($urandom_range(0, 6));
      send($sformatf("rnd%0d", n), f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
